// File: rtl/imm_ext_stage.sv
// Registered immediate extender for the ID/EX boundary: extends the immediate field by mode,
// then delivers it through a main register backed by a one-entry skid register.
module imm_ext_stage #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [1:0]       out_mode
);

   // BRANCH shifts a sign-extended value left by two, so two spare bits are needed
   if (OUT_W < IN_W + 2) begin : g_width_chk
      $error("imm_ext_stage: OUT_W must be >= IN_W+2");
   end

   localparam logic [1:0] MODE_SIGN   = 2'd0;
   localparam logic [1:0] MODE_ZERO   = 2'd1;
   localparam logic [1:0] MODE_UPPER  = 2'd2;
   localparam logic [1:0] MODE_BRANCH = 2'd3;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic [1:0]       mode;
   } ent_t;

   function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                               input logic [1:0]      mode);
      logic [OUT_W-1:0] sx;
      logic [OUT_W-1:0] r;
      sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      case (mode)
         MODE_SIGN:   r = sx;
         MODE_ZERO:   r = {{(OUT_W-IN_W){1'b0}}, imm};
         MODE_UPPER:  r = {imm, {(OUT_W-IN_W){1'b0}}};
         MODE_BRANCH: r = sx << 2;
         default:     r = sx;
      endcase
      return r;
   endfunction

   logic m_vld, s_vld;
   ent_t m_ent, s_ent;
   ent_t in_ent;
   logic in_fire, out_fire;

   assign in_ent.data = extend(in_imm, in_mode);
   assign in_ent.mode = in_mode;

   // ready depends only on registered state, so no combinational path from out_ready
   assign in_ready  = !s_vld;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = m_vld && out_ready;

   assign out_valid = m_vld;
   assign out_data  = m_ent.data;
   assign out_mode  = m_ent.mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld <= 1'b0;
         s_vld <= 1'b0;
         m_ent <= '0;
         s_ent <= '0;
      end else if (flush) begin
         // drop everything in flight; data registers keep their contents
         m_vld <= 1'b0;
         s_vld <= 1'b0;
      end else if (!m_vld || out_fire) begin
         if (s_vld) begin
            m_ent <= s_ent;
            m_vld <= 1'b1;
            s_vld <= 1'b0;
         end else if (in_fire) begin
            m_ent <= in_ent;
            m_vld <= 1'b1;
         end else begin
            m_vld <= 1'b0;
         end
      end else if (in_fire) begin
         s_ent <= in_ent;
         s_vld <= 1'b1;
      end
   end

endmodule
